// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: program ROM port, branch redirect
// and decode-side valid/ready handshake.
interface fetch_unit_if;
  logic [13:0] Rom_addr_in;
  logic        pc_1;
  logic [1:0]  sel_mem_0;
  logic        sel_mem_1;
  logic [15:0] IR_0;
  logic [15:0] IR_1;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        dec_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_is32;
  logic [15:0] instr_pc;
  logic [15:0] fetch_pc;

  modport master (
    output Rom_addr_in, pc_1, sel_mem_0, sel_mem_1,
    output instr_valid, instr, instr_is32, instr_pc, fetch_pc,
    input  IR_0, IR_1, branch_valid, branch_target, dec_ready
  );

  modport slave (
    input  Rom_addr_in, pc_1, sel_mem_0, sel_mem_1,
    input  instr_valid, instr, instr_is32, instr_pc, fetch_pc,
    output IR_0, IR_1, branch_valid, branch_target, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Thumb fetch stage: 16/32-bit instruction fetch from a
// halfword-addressable ROM with stall and branch redirect.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic         clk,
  input logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STALL
  } state_t;

  state_t      state;
  logic [15:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic        is32_q;
  logic [15:0] ipc_q;

  logic        is32;
  logic [31:0] instr_d;
  logic [15:0] step;
  logic [1:0]  sel0;
  logic        sel1;

  assign bus.Rom_addr_in = pc_q[15:2];
  assign bus.pc_1        = pc_q[1];
  assign bus.sel_mem_0   = sel0;
  assign bus.sel_mem_1   = sel1;
  assign bus.fetch_pc    = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_is32  = is32_q;
  assign bus.instr_pc    = ipc_q;

  always_comb begin
    sel0 = 2'd0;
    sel1 = 1'b1;
    unique case (pc_q[1])
      1'b0: begin
        sel0 = 2'd0;
        sel1 = 1'b1;
      end
      1'b1: begin
        sel0 = 2'd2;
        sel1 = 1'b0;
      end
    endcase
  end

  // 11101/11110/11111 prefixes open a 32-bit encoding
  assign is32 = (bus.IR_0[15:13] == 3'b111)
             && (bus.IR_0[12:11] != 2'b00);

  assign instr_d = is32 ? {bus.IR_0, bus.IR_1}
                        : {16'h0000, bus.IR_0};
  assign step    = is32 ? 16'd4 : 16'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      is32_q  <= 1'b0;
      ipc_q   <= '0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN, STALL: begin
          if (bus.branch_valid) begin
            pc_q    <= {bus.branch_target[15:1], 1'b0};
            valid_q <= 1'b0;
            state   <= RUN;
          end else if (!valid_q || bus.dec_ready) begin
            instr_q <= instr_d;
            is32_q  <= is32;
            ipc_q   <= pc_q;
            valid_q <= 1'b1;
            pc_q    <= pc_q + step;
            state   <= RUN;
          end else begin
            state <= STALL;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a halfword ROM model
// that wraps at the 14-bit word address boundary.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [15:0] rom [32768];
  logic [14:0] hidx;

  fetch_unit_if ifc ();

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign hidx     = {ifc.Rom_addr_in, ifc.pc_1};
  assign ifc.IR_0 = rom[hidx];
  assign ifc.IR_1 = rom[hidx + 15'd1];

  function automatic logic [65:0] outs();
    return {ifc.instr_valid, ifc.instr, ifc.instr_is32,
            ifc.instr_pc, ifc.fetch_pc};
  endfunction

  task automatic test_reset();
    logic [18:0] rs;
    rst_n = 1'b0;
    ifc.dec_ready = 1'b1;
    ifc.branch_valid = 1'b0;
    ifc.branch_target = 16'h0000;
    #3;
    checks++;
    if (outs() !== {1'b0, 32'h0, 1'b0, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_out got %h exp %h", outs(),
               {1'b0, 32'h0, 1'b0, 16'h0, 16'h0});
    end
    rs = {ifc.Rom_addr_in, ifc.pc_1, ifc.sel_mem_0, ifc.sel_mem_1};
    checks++;
    if (rs !== {14'h0, 1'b0, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL rom_sel_pc0 got %h exp %h", rs,
               {14'h0, 1'b0, 2'd0, 1'b1});
    end
  endtask

  task automatic test_boot();
    logic [18:0] rs;
    @(negedge clk);
    rst_n = 1'b1;
    ifc.branch_valid = 1'b1;
    ifc.branch_target = 16'h0020;
    @(negedge clk);
    checks++;
    if (outs() !== {1'b0, 32'h0, 1'b0, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL boot_ignore got %h exp %h", outs(),
               {1'b0, 32'h0, 1'b0, 16'h0, 16'h0});
    end
    ifc.branch_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'h0000BF00, 1'b0, 16'h0000, 16'h0002}) begin
      errors++;
      $display("FAIL first_fetch got %h exp %h", outs(),
               {1'b1, 32'h0000BF00, 1'b0, 16'h0000, 16'h0002});
    end
    rs = {ifc.Rom_addr_in, ifc.pc_1, ifc.sel_mem_0, ifc.sel_mem_1};
    checks++;
    if (rs !== {14'h0, 1'b1, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL rom_sel_pc2 got %h exp %h", rs,
               {14'h0, 1'b1, 2'd2, 1'b0});
    end
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'h0000A001, 1'b0, 16'h0002, 16'h0004}) begin
      errors++;
      $display("FAIL second_fetch got %h exp %h", outs(),
               {1'b1, 32'h0000A001, 1'b0, 16'h0002, 16'h0004});
    end
  endtask

  task automatic test_32bit();
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'hF000F800, 1'b1, 16'h0004, 16'h0008}) begin
      errors++;
      $display("FAIL fetch32 got %h exp %h", outs(),
               {1'b1, 32'hF000F800, 1'b1, 16'h0004, 16'h0008});
    end
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'h0000BF00, 1'b0, 16'h0008, 16'h000A}) begin
      errors++;
      $display("FAIL after32 got %h exp %h", outs(),
               {1'b1, 32'h0000BF00, 1'b0, 16'h0008, 16'h000A});
    end
  endtask

  task automatic test_stall();
    ifc.dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== {1'b1, 32'h0000BF00, 1'b0, 16'h0008, 16'h000A}) begin
        errors++;
        $display("FAIL stall_hold%0d got %h exp %h", i, outs(),
                 {1'b1, 32'h0000BF00, 1'b0, 16'h0008, 16'h000A});
      end
    end
    ifc.dec_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'h00002001, 1'b0, 16'h000A, 16'h000C}) begin
      errors++;
      $display("FAIL stall_release got %h exp %h", outs(),
               {1'b1, 32'h00002001, 1'b0, 16'h000A, 16'h000C});
    end
  endtask

  task automatic test_branch_stall();
    ifc.dec_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'h00002001, 1'b0, 16'h000A, 16'h000C}) begin
      errors++;
      $display("FAIL pre_branch_hold got %h exp %h", outs(),
               {1'b1, 32'h00002001, 1'b0, 16'h000A, 16'h000C});
    end
    ifc.branch_valid = 1'b1;
    ifc.branch_target = 16'h0007;
    @(negedge clk);
    checks++;
    if ({ifc.instr_valid, ifc.fetch_pc} !== {1'b0, 16'h0006}) begin
      errors++;
      $display("FAIL branch_flush got %h exp %h",
               {ifc.instr_valid, ifc.fetch_pc}, {1'b0, 16'h0006});
    end
    ifc.branch_valid = 1'b0;
    ifc.dec_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'hF800BF00, 1'b1, 16'h0006, 16'h000A}) begin
      errors++;
      $display("FAIL branch_target got %h exp %h", outs(),
               {1'b1, 32'hF800BF00, 1'b1, 16'h0006, 16'h000A});
    end
  endtask

  task automatic test_wrap32();
    ifc.branch_valid = 1'b1;
    ifc.branch_target = 16'hFFFE;
    ifc.dec_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifc.instr_valid, ifc.fetch_pc, ifc.Rom_addr_in, ifc.pc_1}
        !== {1'b0, 16'hFFFE, 14'h3FFF, 1'b1}) begin
      errors++;
      $display("FAIL branch_accept got %h exp %h",
               {ifc.instr_valid, ifc.fetch_pc, ifc.Rom_addr_in, ifc.pc_1},
               {1'b0, 16'hFFFE, 14'h3FFF, 1'b1});
    end
    ifc.branch_valid = 1'b0;
    rom[32767] = 16'hE800;
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'hE800BF00, 1'b1, 16'hFFFE, 16'h0002}) begin
      errors++;
      $display("FAIL wrap32 got %h exp %h", outs(),
               {1'b1, 32'hE800BF00, 1'b1, 16'hFFFE, 16'h0002});
    end
  endtask

  task automatic test_wrap16();
    rom[32767] = 16'h4600;
    ifc.branch_valid = 1'b1;
    ifc.branch_target = 16'hFFFF;
    @(negedge clk);
    checks++;
    if ({ifc.instr_valid, ifc.fetch_pc} !== {1'b0, 16'hFFFE}) begin
      errors++;
      $display("FAIL branch_bit0 got %h exp %h",
               {ifc.instr_valid, ifc.fetch_pc}, {1'b0, 16'hFFFE});
    end
    ifc.branch_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'h00004600, 1'b0, 16'hFFFE, 16'h0000}) begin
      errors++;
      $display("FAIL wrap16 got %h exp %h", outs(),
               {1'b1, 32'h00004600, 1'b0, 16'hFFFE, 16'h0000});
    end
  endtask

  task automatic test_reset_midstall();
    ifc.dec_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'h00004600, 1'b0, 16'hFFFE, 16'h0000}) begin
      errors++;
      $display("FAIL midstall_hold got %h exp %h", outs(),
               {1'b1, 32'h00004600, 1'b0, 16'hFFFE, 16'h0000});
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== {1'b0, 32'h0, 1'b0, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", outs(),
               {1'b0, 32'h0, 1'b0, 16'h0, 16'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ifc.dec_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== {1'b0, 32'h0, 1'b0, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL reboot got %h exp %h", outs(),
               {1'b0, 32'h0, 1'b0, 16'h0, 16'h0});
    end
    @(negedge clk);
    checks++;
    if (outs() !== {1'b1, 32'h0000BF00, 1'b0, 16'h0000, 16'h0002}) begin
      errors++;
      $display("FAIL refetch got %h exp %h", outs(),
               {1'b1, 32'h0000BF00, 1'b0, 16'h0000, 16'h0002});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32768; i++) rom[i] = 16'hBF00;
    rom[0] = 16'hBF00;
    rom[1] = 16'hA001;
    rom[2] = 16'hF000;
    rom[3] = 16'hF800;
    rom[4] = 16'hBF00;
    rom[5] = 16'h2001;
    rom[6] = 16'h2102;
    test_reset();
    test_boot();
    test_32bit();
    test_stall();
    test_branch_stall();
    test_wrap32();
    test_wrap16();
    test_reset_midstall();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: byte address of the first fetch after reset.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port Rom_addr_in, output, 14: program ROM word address, equal to fetch_pc[15:2].
REQ-005 SHALL have port pc_1, output, 1: equal to fetch_pc[1] (odd-halfword offset).
REQ-006 SHALL have port sel_mem_0, output, 2: ROM IR_0 mux select.
REQ-007 SHALL have port sel_mem_1, output, 1: ROM IR_1 mux select.
REQ-008 SHALL have port IR_0, input, 16: first halfword at fetch_pc, returned combinationally by the ROM.
REQ-009 SHALL have port IR_1, input, 16: halfword at fetch_pc+2, returned combinationally by the ROM.
REQ-010 SHALL have port branch_valid, input, 1: redirect request from execute.
REQ-011 SHALL have port branch_target, input, 16: redirect byte address; bit 0 is ignored.
REQ-012 SHALL have port dec_ready, input, 1: decode accepts instr this cycle.
REQ-013 SHALL have port instr_valid, output, 1: instr holds a valid instruction.
REQ-014 SHALL have port instr, output, 32: {hw0,hw1} for a 32-bit instruction, {16'h0000,hw0} for a 16-bit instruction.
REQ-015 SHALL have port instr_is32, output, 1: instr is a 32-bit Thumb instruction.
REQ-016 SHALL have port instr_pc, output, 16: byte address of instr.
REQ-017 SHALL have port fetch_pc, output, 16: current fetch address.

Function
REQ-018 ROM selects SHALL be combinational from fetch_pc[1]: 0 -> sel_mem_0=0, sel_mem_1=1; 1 -> sel_mem_0=2, sel_mem_1=0; sel_mem_0=1 SHALL never be driven.
REQ-019 The block SHALL classify IR_0 as 32-bit when IR_0[15:11] is 5'b11101, 5'b11110 or 5'b11111, and as 16-bit otherwise.
REQ-020 The FSM SHALL have three states: BOOT, RUN and STALL.
REQ-021 BOOT is entered on reset; it SHALL last one cycle with no capture, then go to RUN.
REQ-022 A load SHALL occur when state is RUN or STALL, !instr_valid || dec_ready, and !branch_valid.
REQ-023 On a load, the output register SHALL capture instr and instr_is32 per REQ-014/019, set instr_pc=fetch_pc and instr_valid=1.
REQ-024 On a load, fetch_pc SHALL advance by +2 for a 16-bit and +4 for a 32-bit instruction, modulo 2^16.
REQ-025 STALL SHALL be entered when instr_valid=1 and dec_ready=0.
REQ-026 While in STALL, instr, instr_is32, instr_pc and fetch_pc SHALL hold stable.
REQ-027 STALL SHALL return to RUN on the cycle dec_ready=1, and a load SHALL occur in that same cycle.
REQ-028 Handshake: a transfer SHALL complete on the edge where instr_valid=1 and dec_ready=1; back-to-back transfers SHALL sustain one instruction per cycle.
REQ-029 branch_valid SHALL have priority over everything in any state except BOOT: fetch_pc <= {branch_target[15:1],1'b0}, instr_valid <= 0, next state RUN.
REQ-030 After a branch, the first load from the target SHALL occur on the following cycle, giving one bubble cycle.
REQ-031 If branch_valid and dec_ready are both high while instr_valid=1, the pending instruction SHALL count as accepted and the branch SHALL still flush.
REQ-032 branch_valid during BOOT SHALL be ignored.
REQ-033 Wrap-around: a 32-bit instruction at 16'hFFFE SHALL take hw1 from ROM word 0, via the ROM's 14-bit address wrap, and fetch_pc SHALL become 16'h0002.
REQ-034 A 16-bit instruction at 16'hFFFE SHALL set fetch_pc to 16'h0000.
REQ-035 instr_is32 and instr[31:16] SHALL be valid only while instr_valid=1; when instr_is32=0, instr[31:16] SHALL be 16'h0000.

Reset
REQ-036 rst_n low SHALL immediately, without waiting for clk, force state=BOOT, fetch_pc=RESET_PC, instr_valid=0, instr=0, instr_is32=0 and instr_pc=0.
REQ-037 Assertion of rst_n mid-stall or mid-branch SHALL discard all pending state; the first fetch after release SHALL be from RESET_PC.

Verification
REQ-038 Reset release with ROM words {BF00,A001,BF00,BF00}, dec_ready=1 -> BOOT for 1 cycle, then instr=0000BF00 @pc 0, 0000A001 @pc 2, one per cycle.
REQ-039 fetch_pc=2 -> Rom_addr_in=0, pc_1=1, sel_mem_0=2, sel_mem_1=0.
REQ-040 32-bit pair F000,F800 at pc 4 -> instr=F000F800, instr_is32=1, next instr_pc=8.
REQ-041 dec_ready held low 3 cycles with instr_valid=1 -> instr, instr_pc and fetch_pc unchanged; release -> next instruction on the following edge.
REQ-042 branch_valid with target 16'h0007 while stalled -> instr_valid=0 next cycle, then instr_pc=16'h0006.
REQ-043 rst_n pulsed low between clock edges during a stall -> outputs zero immediately, then fetch restarts at RESET_PC after BOOT.
